// File: rtl/z_tile_buffer.sv
// Per-tile Z store for the ISP depth test: returns stored depth and test result per fragment,
// commits passing depths, and fills the whole tile with a clear depth on request.
module z_tile_buffer #(
  parameter int TILE_BITS = 5,
  parameter int Z_W       = 32
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        tile_clear,
  input  logic signed [Z_W-1:0]       clear_z,
  output logic                        clear_busy,
  output logic                        clear_done,
  input  logic                        req_valid,
  output logic                        req_ready,
  input  logic [TILE_BITS-1:0]        req_x,
  input  logic [TILE_BITS-1:0]        req_y,
  input  logic signed [Z_W-1:0]       req_z,
  input  logic [2:0]                  depth_comp,
  input  logic                        z_write_disable,
  output logic                        resp_valid,
  output logic                        resp_allow,
  output logic signed [Z_W-1:0]       resp_old_z,
  output logic [TILE_BITS-1:0]        resp_x,
  output logic [TILE_BITS-1:0]        resp_y
);

  localparam int A_W   = 2 * TILE_BITS;
  localparam int DEPTH = 1 << A_W;

  typedef enum logic [1:0] {IDLE, FILL, DONE} clr_state_t;

  clr_state_t               state_q, state_d;
  logic                     clr_pend_q, clr_pend_d;
  logic                     start_fill;
  logic [A_W-1:0]           fill_cnt_q;
  logic signed [Z_W-1:0]    clear_z_q;

  logic signed [Z_W-1:0]    mem [DEPTH];
  logic                     mem_we;
  logic [A_W-1:0]           mem_waddr;
  logic signed [Z_W-1:0]    mem_wdata;

  logic                     accept_p0;
  logic [A_W-1:0]           addr_p0;

  logic                     vld_p1;
  logic [TILE_BITS-1:0]     x_p1, y_p1;
  logic [A_W-1:0]           addr_p1;
  logic signed [Z_W-1:0]    z_p1;
  logic [2:0]               mode_p1;
  logic                     wdis_p1;
  logic signed [Z_W-1:0]    ram_q_p1;
  logic signed [Z_W-1:0]    old_z_p1;
  logic                     allow_p1;
  logic                     resp_we;

  logic                     fwd_vld_q;
  logic [A_W-1:0]           fwd_addr_q;
  logic signed [Z_W-1:0]    fwd_data_q;

  function automatic logic depth_pass(input logic [2:0] mode,
                                      input logic signed [Z_W-1:0] ip_z,
                                      input logic signed [Z_W-1:0] old_z);
    case (mode)
      3'd0:    return 1'b0;
      3'd1:    return ip_z <  old_z;
      3'd2:    return ip_z == old_z;
      3'd3:    return ip_z <= old_z;
      3'd4:    return ip_z >  old_z;
      3'd5:    return ip_z != old_z;
      3'd6:    return ip_z >= old_z;
      default: return 1'b1;
    endcase
  endfunction

  // Stage p0: request acceptance and RAM read address
  assign req_ready = !clear_busy;
  assign accept_p0 = req_valid && req_ready;
  assign addr_p0   = {req_y, req_x};

  // Stage p1: select old depth (forward register covers the read-during-write of the previous request)
  assign addr_p1  = {y_p1, x_p1};
  assign old_z_p1 = (fwd_vld_q && (fwd_addr_q == addr_p1)) ? fwd_data_q : ram_q_p1;
  assign allow_p1 = vld_p1 && depth_pass(mode_p1, z_p1, old_z_p1);
  assign resp_we  = allow_p1 && !wdis_p1 && (state_q != FILL);

  assign resp_valid = vld_p1;
  assign resp_allow = allow_p1;
  assign resp_old_z = vld_p1 ? old_z_p1 : '0;
  assign resp_x     = x_p1;
  assign resp_y     = y_p1;

  assign clear_busy = (state_q == FILL);
  assign clear_done = (state_q == DONE);

  // The fill owns the write port; a response landing in the first fill cycle is superseded by the clear
  assign mem_we    = (state_q == FILL) || resp_we;
  assign mem_waddr = (state_q == FILL) ? fill_cnt_q : addr_p1;
  assign mem_wdata = (state_q == FILL) ? clear_z_q  : z_p1;

  always_ff @(posedge clock) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
    ram_q_p1 <= mem[addr_p0];
  end

  always_comb begin
    state_d    = state_q;
    clr_pend_d = clr_pend_q;
    start_fill = 1'b0;
    case (state_q)
      IDLE: begin
        if (clr_pend_q || (tile_clear && !vld_p1)) begin
          start_fill = 1'b1;
          clr_pend_d = 1'b0;
          state_d    = FILL;
        end else if (tile_clear) begin
          clr_pend_d = 1'b1;
        end
      end
      FILL:    if (fill_cnt_q == '1) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      clr_pend_q <= 1'b0;
      fill_cnt_q <= '0;
      vld_p1     <= 1'b0;
      x_p1       <= '0;
      y_p1       <= '0;
      fwd_vld_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      clr_pend_q <= clr_pend_d;
      vld_p1     <= accept_p0;
      if (state_q == FILL) fill_cnt_q <= fill_cnt_q + 1'b1;
      if (accept_p0) begin
        x_p1 <= req_x;
        y_p1 <= req_y;
      end
      if (start_fill)   fwd_vld_q <= 1'b0;
      else if (resp_we) fwd_vld_q <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (accept_p0) begin
      z_p1    <= req_z;
      mode_p1 <= depth_comp;
      wdis_p1 <= z_write_disable;
    end
    if ((state_q == IDLE) && tile_clear) clear_z_q <= clear_z;
    if (resp_we) begin
      fwd_addr_q <= addr_p1;
      fwd_data_q <= z_p1;
    end
  end

endmodule

// File: tb/tb_z_tile_buffer.sv
// Directed bench for z_tile_buffer: tile-level depth model plus literal expectations.
module tb_z_tile_buffer;
  localparam int N = 1024;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic               reset_n, tile_clear, clear_busy, clear_done;
  logic signed [31:0] clear_z;
  logic               req_valid, req_ready, z_write_disable;
  logic [4:0]         req_x, req_y, resp_x, resp_y;
  logic signed [31:0] req_z, resp_old_z;
  logic [2:0]         depth_comp;
  logic               resp_valid, resp_allow;

  z_tile_buffer #(.TILE_BITS(5), .Z_W(32)) dut (
    .clock(clock), .reset_n(reset_n), .tile_clear(tile_clear), .clear_z(clear_z),
    .clear_busy(clear_busy), .clear_done(clear_done), .req_valid(req_valid),
    .req_ready(req_ready), .req_x(req_x), .req_y(req_y), .req_z(req_z),
    .depth_comp(depth_comp), .z_write_disable(z_write_disable), .resp_valid(resp_valid),
    .resp_allow(resp_allow), .resp_old_z(resp_old_z), .resp_x(resp_x), .resp_y(resp_y)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Tile model: one depth per pixel, fragments applied in issue order.
  logic signed [31:0] mdl [N];
  logic               exp_vld = 1'b0;
  logic               exp_allow = 1'b0;
  logic signed [31:0] exp_old = '0;
  logic [4:0]         exp_x = '0, exp_y = '0;
  int                 m_addr;

  // Relation index: 0 = fragment nearer (less), 1 = equal, 2 = greater; mode bit selects pass.
  function automatic bit ref_allow(input logic [2:0] m, input int ipz, input int old);
    int rel;
    rel = (ipz < old) ? 0 : ((ipz == old) ? 1 : 2);
    return m[rel];
  endfunction

  always @(posedge clock) begin
    exp_vld = 1'b0;
    if (reset_n) begin
      if (req_valid) begin
        m_addr    = {req_y, req_x};
        exp_old   = mdl[m_addr];
        exp_allow = ref_allow(depth_comp, req_z, exp_old);
        if (exp_allow && !z_write_disable) mdl[m_addr] = req_z;
        exp_vld = 1'b1;
        exp_x   = req_x;
        exp_y   = req_y;
      end
      if (tile_clear)
        for (int i = 0; i < N; i++) mdl[i] = clear_z;
    end
  end

  always @(negedge clock) begin
    check("resp_valid", resp_valid, exp_vld);
    if (exp_vld) begin
      check("resp_allow", resp_allow, exp_allow);
      check("resp_old_z", resp_old_z, exp_old);
      check("resp_x", resp_x, exp_x);
      check("resp_y", resp_y, exp_y);
    end
  end

  task automatic step(input bit v, input logic [4:0] x, input logic [4:0] y,
                      input logic [31:0] z, input logic [2:0] m, input bit wd);
    @(posedge clock);
    #1;
    req_valid = v; req_x = x; req_y = y; req_z = z;
    depth_comp = m; z_write_disable = wd; tile_clear = 1'b0;
  endtask

  task automatic lit(input string name, input bit ea, input logic [31:0] eo);
    @(negedge clock);
    check({name, "_valid"}, resp_valid, 1);
    check({name, "_allow"}, resp_allow, ea);
    check({name, "_old"}, resp_old_z, eo);
  endtask

  task automatic single(input string name, input logic [4:0] x, input logic [4:0] y,
                        input logic [31:0] z, input logic [2:0] m, input bit wd,
                        input bit ea, input logic [31:0] eo);
    step(1, x, y, z, m, wd);
    step(0, 0, 0, 0, 0, 0);
    lit(name, ea, eo);
  endtask

  task automatic do_clear(input logic [31:0] cz);
    int busy, done, cyc, rdy_bad;
    @(posedge clock);
    #1;
    req_valid = 1'b0; tile_clear = 1'b1; clear_z = cz;
    @(posedge clock);
    #1;
    tile_clear = 1'b0;
    busy = 0; done = 0; cyc = 0; rdy_bad = 0;
    while (done == 0 && cyc < 1200) begin
      @(negedge clock);
      cyc++;
      if (clear_busy) busy++;
      if (req_ready === clear_busy) rdy_bad++;
      if (clear_done) done++;
    end
    check("clear_busy_cycles", busy, 1024);
    check("clear_done_seen", done, 1);
    check("clear_ready_vs_busy", rdy_bad, 0);
    @(negedge clock);
    check("clear_done_one_pulse", clear_done, 0);
    check("clear_ready_after", req_ready, 1);
  endtask

  logic [7:0] tab [3];
  logic [31:0] zv;

  initial begin
    int busy, cyc, dn;
    reset_n = 1'b0; tile_clear = 1'b0; clear_z = '0; req_valid = 1'b0;
    req_x = '0; req_y = '0; req_z = '0; depth_comp = '0; z_write_disable = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_allow", resp_allow, 0);
    check("rst_resp_old_z", resp_old_z, 0);
    check("rst_resp_xy", {resp_y, resp_x}, 0);
    check("rst_clear_busy", clear_busy, 0);
    check("rst_clear_done", clear_done, 0);
    @(posedge clock);
    #1 reset_n = 1'b1;

    // Clear to most-negative depth and sweep every pixel read-only.
    do_clear(32'h8000_0000);
    for (int i = 0; i < N; i++) step(1, i[4:0], i[9:5], $urandom, 7, 1);
    step(0, 0, 0, 0, 0, 0);
    lit("sweep_last", 1, 32'h8000_0000);

    do_clear(32'h0);
    single("gt_first", 3, 5, 100, 4, 0, 1, 0);
    single("gt_second", 3, 5, 50, 4, 0, 0, 100);

    // Back-to-back same pixel through the forward path.
    step(1, 7, 7, 10, 4, 0);
    step(1, 7, 7, 20, 4, 0);
    lit("b2b_a", 1, 0);
    step(1, 7, 7, 15, 4, 0);
    lit("b2b_b", 1, 10);
    step(0, 0, 0, 0, 0, 0);
    lit("b2b_c", 0, 20);
    single("b2b_final", 7, 7, 0, 0, 1, 0, 20);

    single("sgn_store", 2, 2, 32'hFFFF_FFFF, 7, 0, 1, 0);
    single("sgn_zero", 2, 2, 0, 1, 1, 0, 32'hFFFF_FFFF);
    single("sgn_m2", 2, 2, 32'hFFFF_FFFE, 1, 1, 1, 32'hFFFF_FFFF);

    // Mode table against stored 100: rows are req_z 99/100/101, bit m is mode m.
    tab[0] = 8'b1010_1010; tab[1] = 8'b1100_1100; tab[2] = 8'b1111_0000;
    single("mode_store", 1, 1, 100, 7, 0, 1, 0);
    for (int k = 0; k < 3; k++)
      for (int m = 0; m < 8; m++) begin
        zv = 32'(99 + k);
        single($sformatf("mode%0d_z%0d", m, 99 + k), 1, 1, zv, m[2:0], 1, tab[k][m], 100);
      end
    single("mode0_nowrite", 1, 1, 50, 0, 0, 0, 100);
    single("mode7_wdis", 1, 1, 50, 7, 1, 1, 100);
    single("ram_unchanged", 1, 1, 100, 2, 1, 1, 100);

    // Clear with a request in flight, then reset in the middle of the fill.
    step(1, 4, 4, 555, 7, 0);
    @(posedge clock);
    #1;
    req_valid = 1'b0; tile_clear = 1'b1; clear_z = '0;
    @(posedge clock);
    #1 tile_clear = 1'b0;
    @(negedge clock);
    check("clear_delayed", clear_busy, 0);
    @(negedge clock);
    check("clear_started", clear_busy, 1);
    busy = 1; cyc = 0;
    while (busy < 500 && cyc < 1200) begin
      @(negedge clock);
      cyc++;
      if (clear_busy) busy++;
    end
    check("fill_reached_500", busy, 500);
    @(posedge clock);
    #1 reset_n = 1'b0;
    dn = 0;
    for (int k = 0; k < 25; k++) begin
      @(negedge clock);
      if (clear_done) dn++;
      if (k == 2) reset_n = 1'b1;
    end
    check("midfill_busy", clear_busy, 0);
    check("midfill_ready", req_ready, 1);
    check("midfill_no_done", dn, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
